// File: rtl/if_stage_if.sv
// Instruction-memory port between the fetch stage and instruction memory.
//   instr_read : read request this cycle (fetch -> memory)
//   instr_addr : word-aligned read address (fetch -> memory)
//   instr_out  : read data, valid the cycle after the request (memory -> fetch)
interface if_stage_if;
    localparam int unsigned XLEN = 32;

    logic            instr_read;
    logic [XLEN-1:0] instr_addr;
    logic [XLEN-1:0] instr_out;

    modport master (output instr_read, output instr_addr, input instr_out);
    modport slave  (input instr_read, input instr_addr, output instr_out);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues instruction-memory reads
// and fills the IF/ID register. A one-entry hold buffer keeps the response of
// a read that was in flight when a stall began, so none is lost or repeated.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   stall               : hold IF/ID, suspend fetching
//   redirect_valid/_pc  : restart fetch at redirect_pc (must be word aligned)
//   imem                : instruction-memory port (master side)
//   if_id_valid/pc/instr: IF/ID pipeline register towards decode
//   fetch_fault         : sticky, set by a misaligned redirect
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    if_stage_if.master        imem,
    output logic              if_id_valid,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_instr,
    output logic              fetch_fault
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {RUN, HOLD, FAULT} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] fetch_pc, fetch_pc_n;
    logic            inflight_valid, inflight_valid_n;
    logic [XLEN-1:0] inflight_pc, inflight_pc_n;
    logic            hold_valid, hold_valid_n;
    logic [XLEN-1:0] hold_pc, hold_pc_n;
    logic [XLEN-1:0] hold_instr, hold_instr_n;
    logic            if_id_valid_n;
    logic [XLEN-1:0] if_id_pc_n, if_id_instr_n;
    logic            fetch_fault_n;

    logic redirect_ok_c;
    logic misalign_c;

    // Request generation; a misaligned redirect suppresses the fetch outright.
    always_comb begin
        redirect_ok_c   = rst & redirect_valid & (redirect_pc[1:0] == 2'b00) & (state != FAULT);
        misalign_c      = rst & redirect_valid & (redirect_pc[1:0] != 2'b00) & (state != FAULT);
        imem.instr_read = redirect_ok_c
                        | (rst & !stall & !misalign_c & (state == RUN || state == HOLD));
        imem.instr_addr = redirect_ok_c ? redirect_pc : fetch_pc;
    end

    // Next-state and datapath update.
    always_comb begin
        state_n          = state;
        fetch_pc_n       = fetch_pc;
        inflight_valid_n = 1'b0;
        inflight_pc_n    = inflight_pc;
        hold_valid_n     = hold_valid;
        hold_pc_n        = hold_pc;
        hold_instr_n     = hold_instr;
        if_id_valid_n    = if_id_valid;
        if_id_pc_n       = if_id_pc;
        if_id_instr_n    = if_id_instr;
        fetch_fault_n    = fetch_fault;

        if (imem.instr_read) begin
            fetch_pc_n       = imem.instr_addr + XLEN'(4);
            inflight_valid_n = 1'b1;
            inflight_pc_n    = imem.instr_addr;
        end

        if (state == FAULT) begin
            if_id_valid_n = 1'b0;
        end else if (misalign_c) begin
            state_n       = FAULT;
            fetch_fault_n = 1'b1;
            if_id_valid_n = 1'b0;
            if_id_instr_n = NOP_INSTR;
            hold_valid_n  = 1'b0;
        end else if (redirect_ok_c) begin
            // Returning response belongs to the old path and is dropped.
            state_n       = RUN;
            if_id_valid_n = 1'b0;
            if_id_instr_n = NOP_INSTR;
            hold_valid_n  = 1'b0;
        end else if (state == RUN) begin
            if (stall) begin
                if (inflight_valid) begin
                    hold_valid_n = 1'b1;
                    hold_pc_n    = inflight_pc;
                    hold_instr_n = imem.instr_out;
                    state_n      = HOLD;
                end
            end else begin
                if_id_valid_n = inflight_valid;
                if_id_pc_n    = inflight_pc;
                if_id_instr_n = inflight_valid ? imem.instr_out : NOP_INSTR;
            end
        end else if (!stall) begin
            // HOLD released: the buffered entry fills IF/ID without a bubble.
            if_id_valid_n = hold_valid;
            if_id_pc_n    = hold_pc;
            if_id_instr_n = hold_valid ? hold_instr : NOP_INSTR;
            hold_valid_n  = 1'b0;
            state_n       = RUN;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= RUN;
            fetch_pc       <= RESET_PC;
            inflight_valid <= 1'b0;
            inflight_pc    <= '0;
            hold_valid     <= 1'b0;
            hold_pc        <= '0;
            hold_instr     <= NOP_INSTR;
            if_id_valid    <= 1'b0;
            if_id_pc       <= '0;
            if_id_instr    <= NOP_INSTR;
            fetch_fault    <= 1'b0;
        end else begin
            state          <= state_n;
            fetch_pc       <= fetch_pc_n;
            inflight_valid <= inflight_valid_n;
            inflight_pc    <= inflight_pc_n;
            hold_valid     <= hold_valid_n;
            hold_pc        <= hold_pc_n;
            hold_instr     <= hold_instr_n;
            if_id_valid    <= if_id_valid_n;
            if_id_pc       <= if_id_pc_n;
            if_id_instr    <= if_id_instr_n;
            fetch_fault    <= fetch_fault_n;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, stall/hold, redirect,
// redirect over a held entry, misaligned-redirect fault, and PC wrap-around
// on a second instance reset to 32'hFFFF_FFF8.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        v1, f1, v2, f2;
    logic [31:0] pc1, in1, pc2, in2;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'h0;

    int errors = 0;
    int checks = 0;

    if_stage_if m1 ();
    if_stage_if m2 ();

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem(m1), .if_id_valid(v1), .if_id_pc(pc1),
        .if_id_instr(in1), .fetch_fault(f1)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst(rst), .stall(zero1), .redirect_valid(zero1),
        .redirect_pc(zero32), .imem(m2), .if_id_valid(v2), .if_id_pc(pc2),
        .if_id_instr(in2), .fetch_fault(f2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // One-cycle-latency instruction memories.
    always @(posedge clk) m1.instr_out <= mem(m1.instr_addr);
    always @(posedge clk) m2.instr_out <= mem(m2.instr_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, drive inputs away from the edge, let them settle.
    task automatic step(input logic s, input logic rv, input logic [31:0] rp);
        @(posedge clk);
        #2;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        step(0, 0, 32'h0);
        chk("rst_valid", 32'(v1), 32'h0);
        chk("rst_pc", pc1, 32'h0);
        chk("rst_instr", in1, NOP);
        chk("rst_fault", 32'(f1), 32'h0);
        chk("rst_read", 32'(m1.instr_read), 32'h0);
        chk("rst_pc_wrap", pc2, 32'h0);

        rst = 1'b1; #1;
        chk("c0_read", 32'(m1.instr_read), 32'h1);
        chk("c0_addr", m1.instr_addr, 32'h0);
        chk("c0_addr_wrap", m2.instr_addr, 32'hFFFF_FFF8);

        step(0, 0, 32'h0);
        chk("c1_addr", m1.instr_addr, 32'h4);
        chk("c1_valid", 32'(v1), 32'h0);
        chk("c1_addr_wrap", m2.instr_addr, 32'hFFFF_FFFC);

        step(0, 0, 32'h0);
        chk("c2_valid", 32'(v1), 32'h1);
        chk("c2_pc", pc1, 32'h0);
        chk("c2_instr", in1, mem(32'h0));
        chk("c2_addr", m1.instr_addr, 32'h8);
        chk("c2_addr_wrap", m2.instr_addr, 32'h0);
        chk("c2_pc_wrap", pc2, 32'hFFFF_FFF8);

        step(0, 0, 32'h0);
        chk("c3_pc", pc1, 32'h4);
        chk("c3_pc_wrap", pc2, 32'hFFFF_FFFC);

        step(0, 0, 32'h0);
        chk("c4_pc", pc1, 32'h8);
        chk("c4_pc_wrap", pc2, 32'h0);
        chk("c4_valid_wrap", 32'(v2), 32'h1);

        step(0, 0, 32'h0);
        chk("c5_pc", pc1, 32'hC);

        // 3-cycle stall with 0x10 in IF/ID and 0x14 in flight.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 32'h0);
            chk("stall_read", 32'(m1.instr_read), 32'h0);
            chk("stall_pc", pc1, 32'h10);
            chk("stall_valid", 32'(v1), 32'h1);
        end

        step(0, 0, 32'h0);
        chk("unstall_pc", pc1, 32'h10);
        chk("unstall_addr", m1.instr_addr, 32'h18);

        step(0, 0, 32'h0);
        chk("hold_out_pc", pc1, 32'h14);
        chk("hold_out_instr", in1, mem(32'h14));
        chk("hold_out_valid", 32'(v1), 32'h1);

        step(0, 0, 32'h0);
        chk("after_hold_pc", pc1, 32'h18);
        chk("after_hold_instr", in1, mem(32'h18));

        // Redirect to 0x100 while 0x20 is in flight.
        step(0, 1, 32'h100);
        chk("redir_pc_before", pc1, 32'h1C);
        chk("redir_read", 32'(m1.instr_read), 32'h1);
        chk("redir_addr", m1.instr_addr, 32'h100);

        step(0, 0, 32'h0);
        chk("redir_bubble", 32'(v1), 32'h0);
        chk("redir_next_addr", m1.instr_addr, 32'h104);

        step(0, 0, 32'h0);
        chk("redir_tgt_valid", 32'(v1), 32'h1);
        chk("redir_tgt_pc", pc1, 32'h100);
        chk("redir_tgt_instr", in1, mem(32'h100));

        step(0, 0, 32'h0);
        chk("redir_tgt2_pc", pc1, 32'h104);

        // Enter HOLD, then redirect + stall together.
        step(1, 0, 32'h0);
        chk("hold_entry_pc", pc1, 32'h108);
        chk("hold_entry_read", 32'(m1.instr_read), 32'h0);

        step(1, 1, 32'h300);
        chk("hold_redir_read", 32'(m1.instr_read), 32'h1);
        chk("hold_redir_addr", m1.instr_addr, 32'h300);

        step(0, 0, 32'h0);
        chk("hold_redir_bubble", 32'(v1), 32'h0);
        chk("hold_redir_next", m1.instr_addr, 32'h304);

        step(0, 0, 32'h0);
        chk("hold_redir_tgt_pc", pc1, 32'h300);
        chk("hold_redir_tgt_valid", 32'(v1), 32'h1);
        chk("hold_redir_tgt_instr", in1, mem(32'h300));

        // Misaligned redirect.
        step(0, 1, 32'h102);
        chk("mis_read", 32'(m1.instr_read), 32'h0);

        step(0, 0, 32'h0);
        chk("fault_flag", 32'(f1), 32'h1);
        chk("fault_valid", 32'(v1), 32'h0);
        chk("fault_read", 32'(m1.instr_read), 32'h0);

        step(0, 1, 32'h200);
        chk("fault_redir_read", 32'(m1.instr_read), 32'h0);

        step(1, 0, 32'h0);
        chk("fault_stay_valid", 32'(v1), 32'h0);
        chk("fault_stay_flag", 32'(f1), 32'h1);
        chk("fault_stay_read", 32'(m1.instr_read), 32'h0);

        // Reset clears the fault.
        step(0, 0, 32'h0);
        rst = 1'b0; #1;
        chk("rst2_read", 32'(m1.instr_read), 32'h0);

        step(0, 0, 32'h0);
        chk("rst2_fault", 32'(f1), 32'h0);
        chk("rst2_valid", 32'(v1), 32'h0);
        chk("rst2_instr", in1, NOP);
        chk("rst2_pc", pc1, 32'h0);
        rst = 1'b1; #1;
        chk("rst2_rel_read", 32'(m1.instr_read), 32'h1);
        chk("rst2_rel_addr", m1.instr_addr, 32'h0);

        step(0, 0, 32'h0);
        chk("rst2_bubble", 32'(v1), 32'h0);

        step(0, 0, 32'h0);
        chk("rst2_first_pc", pc1, 32'h0);
        chk("rst2_first_valid", 32'(v1), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
